// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin owner of the byte-wide memory port.
// Serialises 1-4 byte requests into strobed byte transfers.
module mem_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ*32-1:0] addr,
    input  logic [N_REQ*2-1:0]  len,
    input  logic [N_REQ*32-1:0] wdata,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ*32-1:0] rdata,
    output logic [N_REQ-1:0]    gnt,
    output logic                busy,
    output logic [31:0]         m_addr,
    output logic                m_re,
    output logic                m_we,
    output logic [7:0]          m_dout,
    input  logic [7:0]          m_din,
    input  logic                m_ack
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_own;
    logic [1:0]         r_cnt;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [1:0]         r_len;
    logic [31:0]        r_wdata;
    logic [31:0]        r_asm;
    logic [N_REQ-1:0]   r_ack;
    logic [N_REQ*32-1:0] r_rdata;
    logic [N_REQ-1:0]   r_gnt;
    logic               r_busy;
    logic [31:0]        r_m_addr;
    logic               r_m_re;
    logic               r_m_we;
    logic [7:0]         r_m_dout;

    logic               w_any;
    logic [PW-1:0]      w_win;
    logic [PW-1:0]      w_idx;
    logic [N_REQ-1:0]   w_onehot;
    logic [PW-1:0]      w_ptr_nxt;
    logic [31:0]        w_m_addr;
    logic [7:0]         w_m_byte;

    // Offset i from the pointer, wrapped into 0..N_REQ-1.
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p,
                                             input int i);
        int s;
        s = int'(p) + i;
        if (s >= N_REQ) s = s - N_REQ;
        return s[PW-1:0];
    endfunction

    assign w_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
    assign w_ptr_nxt = (r_own == PW'(N_REQ-1)) ? '0 : r_own + 1'b1;
    assign w_m_addr  = r_addr + {30'd0, r_cnt};
    assign w_m_byte  = r_wdata[8*r_cnt +: 8];

    assign ack    = r_ack;
    assign rdata  = r_rdata;
    assign gnt    = r_gnt;
    assign busy   = r_busy;
    assign m_addr = r_m_addr;
    assign m_re   = r_m_re;
    assign m_we   = r_m_we;
    assign m_dout = r_m_dout;

    // Round-robin search: first requester at or after the pointer.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = rr_idx(r_ptr, i);
            if (!w_any && req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // Transaction sequencer: grant, byte strobes, gap, completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_own    <= '0;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_len    <= '0;
            r_wdata  <= '0;
            r_asm    <= '0;
            r_ack    <= '0;
            r_rdata  <= '0;
            r_gnt    <= '0;
            r_busy   <= 1'b0;
            r_m_addr <= '0;
            r_m_re   <= 1'b0;
            r_m_we   <= 1'b0;
            r_m_dout <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_own   <= w_win;
                        r_we    <= we[w_win];
                        r_addr  <= addr[32*w_win +: 32];
                        r_len   <= len[2*w_win +: 2];
                        r_wdata <= wdata[32*w_win +: 32];
                        r_asm   <= '0;
                        r_cnt   <= '0;
                        r_gnt   <= w_onehot;
                        r_busy  <= 1'b1;
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (!r_m_re && !r_m_we) begin
                        // First cycle after grant: raise the strobe.
                        r_m_addr <= w_m_addr;
                        r_m_dout <= w_m_byte;
                        r_m_we   <= r_we;
                        r_m_re   <= !r_we;
                    end else if (m_ack) begin
                        r_m_re <= 1'b0;
                        r_m_we <= 1'b0;
                        if (!r_we) r_asm[8*r_cnt +: 8] <= m_din;
                        if (r_cnt == r_len) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= r_cnt + 2'd1;
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    // One low cycle done; strobe the next byte.
                    r_m_addr <= w_m_addr;
                    r_m_dout <= w_m_byte;
                    r_m_we   <= r_we;
                    r_m_re   <= !r_we;
                    r_state  <= S_XFER;
                end
                S_DONE: begin
                    r_ack[r_own] <= 1'b1;
                    if (!r_we) r_rdata[32*r_own +: 32] <= r_asm;
                    r_ptr   <= w_ptr_nxt;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with a
// one-cycle-ack byte memory model.
module tb_mem_arbiter;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   we = '0;
    logic [N*32-1:0] addr = '0;
    logic [N*2-1:0] len = '0;
    logic [N*32-1:0] wdata = '0;
    logic [N-1:0]   ack;
    logic [N*32-1:0] rdata;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [31:0]    m_addr;
    logic           m_re;
    logic           m_we;
    logic [7:0]     m_dout;
    logic [7:0]     m_din = '0;
    logic           m_ack = 1'b0;

    int n_assert = 0;
    int n_fail = 0;
    int exp_acks = 0;

    int ack_cnt = 0;
    int both_cnt = 0;
    int nr = 0;
    int nw = 0;
    int spur_cnt = 0;
    bit spur_en = 1'b0;
    bit seen = 1'b0;
    bit real_ack = 1'b0;
    logic [31:0] rlog [64];
    logic [31:0] wlog_a [64];
    logic [7:0]  wlog_d [64];

    mem_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
        .len(len), .wdata(wdata), .ack(ack), .rdata(rdata),
        .gnt(gnt), .busy(busy), .m_addr(m_addr), .m_re(m_re),
        .m_we(m_we), .m_dout(m_dout), .m_din(m_din), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            default: return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // Memory: acks one cycle after it sees a strobe; optional
    // spurious ack in the cycle right after each real ack.
    always @(negedge clk) begin
        m_ack = 1'b0;
        if (!rst) begin
            seen = 1'b0;
            real_ack = 1'b0;
        end else if (real_ack) begin
            real_ack = 1'b0;
            seen = 1'b0;
            if (spur_en) begin
                m_ack = 1'b1;
                m_din = 8'hEE;
                spur_cnt++;
            end
        end else if (m_re || m_we) begin
            if (!seen) begin
                seen = 1'b1;
            end else begin
                real_ack = 1'b1;
                m_ack = 1'b1;
                m_din = mem_byte(m_addr);
                if (m_we && nw < 64) begin
                    wlog_a[nw] = m_addr;
                    wlog_d[nw] = m_dout;
                    nw++;
                end
                if (m_re && nr < 64) begin
                    rlog[nr] = m_addr;
                    nr++;
                end
            end
        end
    end

    always @(negedge clk) begin
        ack_cnt += $countones(ack);
        if (m_re && m_we) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xact(input int k, input logic w,
                        input logic [31:0] a, input logic [1:0] l,
                        input logic [31:0] d, input int hold,
                        output int lat);
        @(negedge clk);
        we[k] = w;
        addr[32*k +: 32] = a;
        len[2*k +: 2] = l;
        wdata[32*k +: 32] = d;
        req[k] = 1'b1;
        @(posedge clk);
        #1;
        check("grant", 32'(gnt), 32'(1 << k));
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat >= hold) req[k] = 1'b0;
            if (ack[k] === 1'b1) break;
        end
        req[k] = 1'b0;
        exp_acks++;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
        check("ack_one_cycle", 32'(ack), 32'd0);
        check("ack_count", 32'(ack_cnt), 32'(exp_acks));
    endtask

    initial begin
        int lat;
        int b_r;
        int b_w;
        int b_s;
        int k;
        int ng;
        logic [N-1:0] prev;
        logic [N-1:0] order [6];
        logic [N-1:0] exp_order [6];

        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_re", 32'(m_re), 32'd0);
        check("rst_m_we", 32'(m_we), 32'd0);
        check("rst_m_dout", 32'(m_dout), 32'd0);
        check("rst_rdata0", rdata[31:0], 32'd0);
        check("rst_rdata2", rdata[95:64], 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // 4-byte read by requester 0
        b_r = nr;
        xact(0, 1'b0, 32'h100, 2'd3, 32'd0, 1, lat);
        check("t1_latency", 32'(lat), 32'd13);
        check("t1_bytes", 32'(nr - b_r), 32'd4);
        for (int i = 0; i < 4; i++)
            check("t1_m_addr", rlog[b_r + i], 32'h100 + 32'(i));
        check("t1_rdata", rdata[31:0], 32'h44332211);
        settle();

        // 2-byte write by requester 2
        b_r = nr;
        b_w = nw;
        xact(2, 1'b1, 32'h20, 2'd1, 32'hA1B2C3D4, 1, lat);
        check("t2_latency", 32'(lat), 32'd7);
        check("t2_wr_bytes", 32'(nw - b_w), 32'd2);
        check("t2_rd_bytes", 32'(nr - b_r), 32'd0);
        check("t2_addr0", wlog_a[b_w], 32'h20);
        check("t2_data0", 32'(wlog_d[b_w]), 32'hD4);
        check("t2_addr1", wlog_a[b_w + 1], 32'h21);
        check("t2_data1", 32'(wlog_d[b_w + 1]), 32'hC3);
        check("t2_rdata", rdata[95:64], 32'd0);
        settle();

        // Address wrap, 2-byte read by requester 1
        b_r = nr;
        xact(1, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'd0, 1, lat);
        check("t4_latency", 32'(lat), 32'd7);
        check("t4_addr0", rlog[b_r], 32'hFFFF_FFFF);
        check("t4_addr1", rlog[b_r + 1], 32'h0000_0000);
        check("t4_rdata", rdata[63:32], 32'h0000_A55A);
        settle();

        // Spurious acks in gaps, req dropped mid-transfer
        b_r = nr;
        b_s = spur_cnt;
        spur_en = 1'b1;
        xact(1, 1'b0, 32'h100, 2'd3, 32'd0, 5, lat);
        spur_en = 1'b0;
        check("t5_latency", 32'(lat), 32'd13);
        check("t5_bytes", 32'(nr - b_r), 32'd4);
        check("t5_spurious", 32'(spur_cnt - b_s), 32'd4);
        check("t5_rdata", rdata[63:32], 32'h44332211);
        check("t5_lane0_hold", rdata[31:0], 32'h44332211);
        settle();

        // Reset during the first byte of a 4-byte read
        @(negedge clk);
        we[0] = 1'b0;
        addr[31:0] = 32'h100;
        len[1:0] = 2'd3;
        req[0] = 1'b1;
        k = 0;
        while (!m_re && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t6_strobe_up", 32'(m_re), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t6_m_re", 32'(m_re), 32'd0);
        check("t6_m_we", 32'(m_we), 32'd0);
        check("t6_gnt", 32'(gnt), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_no_ack", 32'(ack), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_ack_count", 32'(ack_cnt), 32'(exp_acks));
        xact(1, 1'b0, 32'h200, 2'd0, 32'd0, 1, lat);
        check("t6_latency", 32'(lat), 32'd4);
        check("t6_rdata", rdata[63:32], 32'h0000_00A5);
        settle();

        // Round robin with all requests held from reset
        @(negedge clk);
        rst = 1'b0;
        we = '0;
        len = '0;
        addr = {32'h320, 32'h310, 32'h300};
        req = '1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        prev = '0;
        ng = 0;
        k = 0;
        while (ng < 6 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (gnt != '0 && prev == '0) begin
                order[ng] = gnt;
                ng++;
            end
            prev = gnt;
        end
        req = '0;
        check("t3_grants", 32'(ng), 32'd6);
        for (int i = 0; i < 6; i++)
            check("t3_order", 32'(order[i]), 32'(exp_order[i]));
        exp_acks += 6;
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("t3_busy_end", 32'(busy), 32'd0);
        check("t3_ack_count", 32'(ack_cnt), 32'(exp_acks));

        check("strobe_exclusive", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
